// File: rtl/sqd_programmable.sv
// sqd_programmable: programmable serial pattern detector.
// A pattern of 2..PAT_MAX bits is loaded at run time. Serial bits are then
// matched against it in overlapping or non-overlapping mode, and a
// registered one-cycle pulse marks each match.
// Optional feature: define SQD_MATCH_COUNT_EN to get a saturating match
// counter on MATCH_CNT. Without it, MATCH_CNT is tied to 0 and CNT_CLR is
// ignored.
module sqd_programmable #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 16
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic                             X,
  input  logic                             X_VALID,
  input  logic                             LOAD,
  input  logic [PAT_MAX-1:0]               PAT,
  input  logic [$clog2(PAT_MAX+1)-1:0]     PAT_LEN,
  input  logic                             OVERLAP,
  input  logic                             CNT_CLR,
  output logic                             Z_OUT,
  output logic                             LOAD_ERR,
  output logic [CNT_W-1:0]                 MATCH_CNT
);

  localparam int LEN_W = $clog2(PAT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,  // no valid pattern latched
    ST_FILL,  // fewer than len_q bits collected since load or last match
    ST_RUN    // history holds at least len_q bits
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_MAX-1:0] hist_q,  hist_d;
  logic [LEN_W-1:0]   fill_q,  fill_d;
  logic [PAT_MAX-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic               ovl_q,   ovl_d;
  logic               z_q,     z_d;
  logic               err_q,   err_d;

  logic [PAT_MAX-1:0] mask;
  logic [PAT_MAX-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               len_ok;

  // Compare mask selecting the low len_q bits, plus the shifted history and
  // the saturating fill count that an accepted bit would produce.
  always_comb begin
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hist_shift = {hist_q[PAT_MAX-2:0], X};
    fill_inc   = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
    len_ok     = (PAT_LEN >= LEN_W'(2)) && (PAT_LEN <= LEN_W'(PAT_MAX));
  end

  // Next-state logic: LOAD has priority over data, and data is ignored in IDLE.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through this
    // block leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    z_d     = 1'b0;

    if (LOAD) begin
      hist_d = '0;
      fill_d = '0;
      if (len_ok) begin
        pat_d   = PAT;
        len_d   = PAT_LEN;
        ovl_d   = OVERLAP;
        err_d   = 1'b0;
        state_d = ST_FILL;
      end else begin
        pat_d   = '0;
        len_d   = '0;
        ovl_d   = 1'b0;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (X_VALID && (state_q != ST_IDLE)) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (fill_inc == len_q) begin
        state_d = ST_RUN;
        if ((hist_shift & mask) == (pat_q & mask)) begin
          z_d = 1'b1;
          if (!ovl_q) begin
            // Non-overlapping: the next match needs len_q fresh bits.
            fill_d  = '0;
            state_d = ST_FILL;
          end
        end
      end else begin
        state_d = ST_FILL;
      end
    end
  end

  // State registers; reset discards the latched pattern, so a new LOAD is required.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values from
      // before the edge, which is what removes order dependence between them.
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  assign Z_OUT    = z_q;
  assign LOAD_ERR = err_q;

`ifdef SQD_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter. A clear in the same cycle as a match wins.
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (z_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign MATCH_CNT = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = CNT_CLR;
  assign MATCH_CNT      = '0;
`endif

endmodule

// File: tb/tb_sqd_programmable.sv
// tb_sqd_programmable: table-driven bench for sqd_programmable.
// Each driven bit pushes its expected Z_OUT onto a scoreboard queue. The
// entry is popped and compared one cycle later, once the registered pulse
// is due. Expected MATCH_CNT follows SQD_MATCH_COUNT_EN.
module tb_sqd_programmable;

  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(PAT_MAX + 1);
`ifdef SQD_MATCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               CLK;
  logic               RESET_N;
  logic               X;
  logic               X_VALID;
  logic               LOAD;
  logic [PAT_MAX-1:0] PAT;
  logic [LEN_W-1:0]   PAT_LEN;
  logic               OVERLAP;
  logic               CNT_CLR;
  logic               Z_OUT;
  logic               LOAD_ERR;
  logic [CNT_W-1:0]   MATCH_CNT;

  sqd_programmable #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .X         (X),
    .X_VALID   (X_VALID),
    .LOAD      (LOAD),
    .PAT       (PAT),
    .PAT_LEN   (PAT_LEN),
    .OVERLAP   (OVERLAP),
    .CNT_CLR   (CNT_CLR),
    .Z_OUT     (Z_OUT),
    .LOAD_ERR  (LOAD_ERR),
    .MATCH_CNT (MATCH_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic x;
    logic v;
    logic exp_z;
  } vec_t;

  vec_t vec_q[$];
  logic exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  // Drive one cycle of stimulus and score Z_OUT after the sampling edge.
  task automatic step(input logic x, input logic v, input logic clr, input logic z,
                      input string name);
    X       = x;
    X_VALID = v;
    CNT_CLR = clr;
    exp_q.push_back(z);
    @(posedge CLK);
    #1;
    X_VALID = 1'b0;
    CNT_CLR = 1'b0;
    check(name, {31'd0, Z_OUT}, {31'd0, exp_q.pop_front()});
  endtask

  task automatic add(input logic x, input logic v, input logic z);
    vec_t t;
    t.x     = x;
    t.v     = v;
    t.exp_z = z;
    vec_q.push_back(t);
  endtask

  task automatic run_vecs(input string name);
    foreach (vec_q[i]) begin
      step(vec_q[i].x, vec_q[i].v, 1'b0, vec_q[i].exp_z, $sformatf("%s[%0d]", name, i));
    end
    vec_q.delete();
  endtask

  task automatic load(input logic [PAT_MAX-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl, input logic xv, input logic x);
    PAT     = pat;
    PAT_LEN = len;
    OVERLAP = ovl;
    LOAD    = 1'b1;
    X_VALID = xv;
    X       = x;
    @(posedge CLK);
    #1;
    LOAD    = 1'b0;
    X_VALID = 1'b0;
    check("load_z", {31'd0, Z_OUT}, 32'd0);
  endtask

  task automatic clr_cnt();
    step(1'b0, 1'b0, 1'b1, 1'b0, "cnt_clr_z");
    check("cnt_after_clr", 32'(MATCH_CNT), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b1;
    X = 1'b0; X_VALID = 1'b0; LOAD = 1'b0; PAT = '0; PAT_LEN = '0;
    OVERLAP = 1'b0; CNT_CLR = 1'b0;
    #1 RESET_N = 1'b0;
    #3;
    check("rst_z", {31'd0, Z_OUT}, 32'd0);
    check("rst_err", {31'd0, LOAD_ERR}, 32'd0);
    check("rst_cnt", 32'(MATCH_CNT), 32'd0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;

    // IDLE after reset: a full pattern on X must not produce a pulse.
    PAT = 8'b1011; PAT_LEN = 4'd4; OVERLAP = 1'b1;
    add(1,1,0); add(0,1,0); add(1,1,0); add(1,1,0);
    run_vecs("idle_ignore");

    // Overlapping detection: pulses after bits 4 and 7.
    load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    clr_cnt();
    add(1,1,0); add(0,1,0); add(1,1,0); add(1,1,1); add(0,1,0); add(1,1,0); add(1,1,1);
    run_vecs("ovl");
    check("ovl_cnt", 32'(MATCH_CNT), exp_cnt(2));

    // Non-overlapping detection: pulse only after bit 4.
    load(8'b1011, 4'd4, 1'b0, 1'b0, 1'b0);
    clr_cnt();
    add(1,1,0); add(0,1,0); add(1,1,0); add(1,1,1); add(0,1,0); add(1,1,0); add(1,1,0);
    run_vecs("novl");
    check("novl_cnt", 32'(MATCH_CNT), exp_cnt(1));

    // Rejected loads: LOAD_ERR is set and the previous pattern is discarded.
    load(8'b1011, 4'd0, 1'b1, 1'b0, 1'b0);
    check("err_len0", {31'd0, LOAD_ERR}, 32'd1);
    load(8'b1011, 4'(PAT_MAX + 1), 1'b1, 1'b0, 1'b0);
    check("err_lenmax1", {31'd0, LOAD_ERR}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, $sformatf("err_rand[%0d]", i));
    end
    add(1,1,0); add(0,1,0); add(1,1,0); add(1,1,0);
    run_vecs("err_nomatch");
    load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    check("err_cleared", {31'd0, LOAD_ERR}, 32'd0);

    // Gaps in X_VALID; an invalid 1 after 1,0,1 would complete the match if accepted.
    add(1,1,0); add(1,0,0); add(0,1,0); add(1,0,0); add(0,0,0);
    add(1,1,0); add(1,0,0); add(0,0,0); add(1,1,1); add(1,0,0); add(1,0,0);
    run_vecs("gaps");

    // Pattern inputs changing without LOAD leave the latched pattern unchanged.
    load(8'b1011, 4'd4, 1'b0, 1'b0, 1'b0);
    PAT = 8'b0000; PAT_LEN = 4'd2; OVERLAP = 1'b1;
    add(1,1,0); add(0,1,0); add(1,1,0); add(1,1,1);
    run_vecs("no_load_change");

    // LOAD with X_VALID: the bit on X is discarded.
    load(8'b1011, 4'd4, 1'b1, 1'b1, 1'b1);
    add(0,1,0); add(1,1,0); add(1,1,0); add(0,1,0); add(1,1,0); add(1,1,1);
    run_vecs("load_prec");

    // Longest pattern (PAT_LEN = PAT_MAX).
    load(8'b10010111, 4'd8, 1'b0, 1'b0, 1'b0);
    add(1,1,0); add(0,1,0); add(0,1,0); add(1,1,0);
    add(0,1,0); add(1,1,0); add(1,1,0); add(1,1,1);
    run_vecs("len_max");

    // Shortest pattern, counter saturation, and clear winning over a match.
    load(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
    clr_cnt();
    add(1,1,0); add(1,1,1); add(1,1,1); add(1,1,1); add(1,1,1); add(1,1,1);
    run_vecs("sat");
    check("sat_cnt", 32'(MATCH_CNT), exp_cnt(3));
    step(1'b1, 1'b1, 1'b1, 1'b1, "clr_match_z");
    check("clr_wins_cnt", 32'(MATCH_CNT), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "after_clr_z");
    check("after_clr_cnt", 32'(MATCH_CNT), exp_cnt(1));

    // Reset in mid-stream: detection stays off until the next LOAD.
    load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    add(1,1,0); add(0,1,0); add(1,1,0);
    run_vecs("mid_pre");
    RESET_N = 1'b0;
    #2;
    check("mid_rst_z", {31'd0, Z_OUT}, 32'd0);
    check("mid_rst_cnt", 32'(MATCH_CNT), 32'd0);
    #1 RESET_N = 1'b1;
    add(1,1,0); add(1,1,0); add(0,1,0); add(1,1,0); add(1,1,0);
    run_vecs("mid_post");
    load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    add(1,1,0); add(0,1,0); add(1,1,0); add(1,1,1);
    run_vecs("mid_reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
